// File: rtl/bf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bf_pkg
// Brief    : Opcodes, FSM state encodings and helpers for the tape-machine core.
// Revision : 1.0
// ============================================================================
package bf_pkg;

  localparam int INSTR_WIDTH = 4;
  localparam int STATE_WIDTH = 4;

  typedef enum logic [INSTR_WIDTH-1:0] {
    OP_INC    = 4'd0,
    OP_DEC    = 4'd1,
    OP_INCSP  = 4'd2,
    OP_DECSP  = 4'd3,
    OP_LOOPZ  = 4'd4,
    OP_LOOPNZ = 4'd5,
    OP_CIN    = 4'd6,
    OP_COUT   = 4'd7,
    OP_HALT   = 4'd8
  } opcode_t;

  localparam logic [STATE_WIDTH-1:0] c_s_fetch    = 4'd0;
  localparam logic [STATE_WIDTH-1:0] c_s_decode   = 4'd1;
  localparam logic [STATE_WIDTH-1:0] c_s_exec     = 4'd2;
  localparam logic [STATE_WIDTH-1:0] c_s_skip_f   = 4'd3;
  localparam logic [STATE_WIDTH-1:0] c_s_skip_c   = 4'd4;
  localparam logic [STATE_WIDTH-1:0] c_s_in_wait  = 4'd5;
  localparam logic [STATE_WIDTH-1:0] c_s_out_wait = 4'd6;
  localparam logic [STATE_WIDTH-1:0] c_s_halt     = 4'd7;
  localparam logic [STATE_WIDTH-1:0] c_s_error    = 4'd8;

  function automatic logic is_legal(input logic [INSTR_WIDTH-1:0] op);
    return (op <= OP_HALT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bf_loop_stack.sv
`default_nettype none
// ============================================================================
// Module   : bf_loop_stack
// Brief    : LOOP_DEPTH x PC_WIDTH LIFO holding open-loop return addresses.
// Revision : 1.0
// ============================================================================
module bf_loop_stack #(
  parameter int LOOP_DEPTH = 16,
  parameter int PC_WIDTH   = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [PC_WIDTH-1:0] top,
  output logic                full,
  output logic                empty
);

  localparam int                c_ptr_w = $clog2(LOOP_DEPTH);
  localparam logic [c_ptr_w:0]  c_full  = (c_ptr_w+1)'(LOOP_DEPTH);

  logic [c_ptr_w:0]    r_count;
  logic [PC_WIDTH-1:0] r_mem [LOOP_DEPTH];
  logic [c_ptr_w-1:0]  w_top_idx;

  assign full      = (r_count == c_full);
  assign empty     = (r_count == '0);
  // Low bits wrap to the last slot when the stack is exactly full.
  assign w_top_idx = r_count[c_ptr_w-1:0] - 1'b1;
  assign top       = r_mem[w_top_idx];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (push && !full) begin
      r_count <= r_count + 1'b1;
    end else if (pop && !empty) begin
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) begin
      r_mem[r_count[c_ptr_w-1:0]] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bf_core_p.sv
`default_nettype none
// ============================================================================
// Module   : bf_core_p
// Brief    : Parametrised tape-machine core with loop stack, skip scan and I/O.
// Revision : 1.0
// ============================================================================
module bf_core_p
  import bf_pkg::*;
#(
  parameter int CELL_WIDTH = 8,
  parameter int TAPE_AW    = 16,
  parameter int PC_WIDTH   = 16,
  parameter int LOOP_DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic [PC_WIDTH-1:0]    pmem_addr,
  input  logic [INSTR_WIDTH-1:0] pmem_data_read,
  output logic [TAPE_AW-1:0]     tape_addr,
  input  logic [CELL_WIDTH-1:0]  tape_data_read,
  output logic                   tape_we,
  output logic [CELL_WIDTH-1:0]  tape_data_write,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CELL_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CELL_WIDTH-1:0]  out_data,
  output logic                   halted,
  output logic                   error
);

  localparam logic [PC_WIDTH-1:0] c_nest_one = PC_WIDTH'(1);

  logic [STATE_WIDTH-1:0] r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [TAPE_AW-1:0]     r_sp;
  logic [INSTR_WIDTH-1:0] r_op;
  logic [CELL_WIDTH-1:0]  r_cell;
  logic [PC_WIDTH-1:0]    r_nest;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [CELL_WIDTH-1:0]  r_out_data;

  logic                   w_push;
  logic                   w_pop;
  logic [PC_WIDTH-1:0]    w_top;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_cell_nz;
  logic [PC_WIDTH-1:0]    w_pc_inc;
  logic                   w_we;
  logic [CELL_WIDTH-1:0]  w_wd;

  assign w_cell_nz = (r_cell != '0);
  assign w_pc_inc  = r_pc + 1'b1;
  assign w_push    = (r_state == c_s_exec) && (r_op == OP_LOOPZ) && w_cell_nz && !w_full;
  assign w_pop     = (r_state == c_s_exec) && (r_op == OP_LOOPNZ) && !w_cell_nz && !w_empty;

  bf_loop_stack #(
    .LOOP_DEPTH (LOOP_DEPTH),
    .PC_WIDTH   (PC_WIDTH)
  ) u_stack (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (r_pc),
    .top       (w_top),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Writes are decoded from state so reset or a terminal state can never leave a strobe high.
  always_comb begin
    w_we = 1'b0;
    w_wd = '0;
    if (r_state == c_s_exec && (r_op == OP_INC || r_op == OP_DEC)) begin
      w_we = 1'b1;
      w_wd = (r_op == OP_INC) ? r_cell + 1'b1 : r_cell - 1'b1;
    end else if (r_state == c_s_in_wait && in_valid && r_in_ready) begin
      w_we = 1'b1;
      w_wd = in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= c_s_fetch;
      r_pc        <= '0;
      r_sp        <= '0;
      r_op        <= '0;
      r_cell      <= '0;
      r_nest      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        c_s_fetch: r_state <= c_s_decode;
        c_s_decode: begin
          r_op   <= pmem_data_read;
          r_cell <= tape_data_read;
          case (pmem_data_read)
            OP_CIN: begin
              r_state    <= c_s_in_wait;
              r_in_ready <= 1'b1;
            end
            OP_COUT: begin
              r_state     <= c_s_out_wait;
              r_out_valid <= 1'b1;
              r_out_data  <= tape_data_read;
            end
            OP_HALT: r_state <= c_s_halt;
            default: r_state <= is_legal(pmem_data_read) ? c_s_exec : c_s_error;
          endcase
        end
        c_s_exec: begin
          r_state <= c_s_fetch;
          r_pc    <= w_pc_inc;
          case (r_op)
            OP_INCSP: r_sp <= r_sp + 1'b1;
            OP_DECSP: r_sp <= r_sp - 1'b1;
            OP_LOOPZ: begin
              if (w_cell_nz) begin
                if (w_full) r_state <= c_s_error;
              end else begin
                r_nest  <= c_nest_one;
                r_state <= (r_pc == '1) ? c_s_error : c_s_skip_f;
              end
            end
            OP_LOOPNZ: begin
              if (w_empty) r_state <= c_s_error;
              else if (w_cell_nz) r_pc <= w_top + 1'b1;
            end
            default: ;
          endcase
        end
        c_s_skip_f: r_state <= c_s_skip_c;
        c_s_skip_c: begin
          if (pmem_data_read == OP_LOOPNZ && r_nest == c_nest_one) begin
            r_pc    <= w_pc_inc;
            r_state <= c_s_fetch;
          end else if (r_pc == '1) begin
            r_state <= c_s_error;
          end else begin
            r_pc    <= w_pc_inc;
            r_state <= c_s_skip_f;
            if (pmem_data_read == OP_LOOPZ) r_nest <= r_nest + 1'b1;
            else if (pmem_data_read == OP_LOOPNZ) r_nest <= r_nest - 1'b1;
          end
        end
        c_s_in_wait: begin
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_pc       <= w_pc_inc;
            r_state    <= c_s_fetch;
          end
        end
        c_s_out_wait: begin
          if (out_ready && r_out_valid) begin
            r_out_valid <= 1'b0;
            r_pc        <= w_pc_inc;
            r_state     <= c_s_fetch;
          end
        end
        default: ;
      endcase
    end
  end

  assign pmem_addr       = r_pc;
  assign tape_addr       = r_sp;
  assign tape_we         = w_we;
  assign tape_data_write = w_wd;
  assign in_ready        = r_in_ready;
  assign out_valid       = r_out_valid;
  assign out_data        = r_out_data;
  assign halted          = (r_state == c_s_halt);
  assign error           = (r_state == c_s_error);

endmodule
`default_nettype wire

// File: tb/tb_bf_core_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_bf_core_p
// Brief    : Directed self-checking bench for bf_core_p with ROM/RAM models.
// Revision : 1.0
// ============================================================================
module tb_bf_core_p;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] pmem_addr;
  logic [3:0]  pmem_data_read;
  logic [15:0] tape_addr;
  logic [7:0]  tape_data_read;
  logic        tape_we;
  logic [7:0]  tape_data_write;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        halted;
  logic        error;

  logic [3:0]  rom  [0:255];
  logic [7:0]  tape [0:255];
  logic        clr;
  int          wr_cnt;
  int          out_cnt;
  logic [7:0]  last_out;
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  bf_core_p dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .pmem_addr       (pmem_addr),
    .pmem_data_read  (pmem_data_read),
    .tape_addr       (tape_addr),
    .tape_data_read  (tape_data_read),
    .tape_we         (tape_we),
    .tape_data_write (tape_data_write),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .halted          (halted),
    .error           (error)
  );

  // Synchronous ROM and tape RAM: read data appears one cycle after the address.
  always @(posedge clock) begin
    pmem_data_read <= rom[pmem_addr[7:0]];
    tape_data_read <= tape[tape_addr[7:0]];
    if (clr) begin
      for (int i = 0; i < 256; i++) tape[i] <= 8'h00;
    end else if (tape_we) begin
      tape[tape_addr[7:0]] <= tape_data_write;
    end
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt   <= 0;
      out_cnt  <= 0;
      last_out <= 8'h00;
    end else begin
      if (tape_we) wr_cnt <= wr_cnt + 1;
      if (out_valid && out_ready) begin
        out_cnt  <= out_cnt + 1;
        last_out <= out_data;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [127:0] prog, input int n, input bit clear);
    @(negedge clock);
    reset_n  = 1'b0;
    clr      = clear;
    in_valid = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 4'd8;
    for (int i = 0; i < n; i++) rom[i] = prog[4*i +: 4];
    @(negedge clock);
    clr = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  task automatic run_to_end(input string tag, input int bound);
    while (!(halted || error) && cyc < bound) begin
      @(posedge clock);
      cyc++;
      #1;
    end
    if (!(halted || error)) check({tag, "_timeout"}, {31'b0, halted | error}, 32'd1);
  endtask

  task automatic wait_cond(input string tag, input int sel, input int bound);
    int k;
    k = 0;
    while (!((sel == 0) ? in_ready : out_valid) && k < bound) begin
      @(posedge clock);
      cyc++;
      k++;
      #1;
    end
    check({tag, "_wait"}, {31'b0, (sel == 0) ? in_ready : out_valid}, 32'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    clr       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 4'd8;
    repeat (3) @(negedge clock);
    clr = 1'b0;
    check("rst_pc",        {16'b0, pmem_addr}, 32'h0);
    check("rst_sp",        {16'b0, tape_addr}, 32'h0);
    check("rst_we",        {31'b0, tape_we}, 32'h0);
    check("rst_wdata",     {24'b0, tape_data_write}, 32'h0);
    check("rst_in_ready",  {31'b0, in_ready}, 32'h0);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_data",  {24'b0, out_data}, 32'h0);
    check("rst_status",    {30'b0, halted, error}, 32'h0);

    // INC,INC,COUT,HALT
    out_ready = 1'b1;
    start(128'h8700, 4, 1'b1);
    run_to_end("p1", 200);
    check("p1_halted",  {31'b0, halted}, 32'd1);
    check("p1_cycles",  cyc, 32'd11);
    check("p1_out",     {24'b0, last_out}, 32'h02);
    check("p1_out_cnt", out_cnt, 32'd1);

    // ++[-] COUT HALT
    start(128'h8751400, 7, 1'b1);
    run_to_end("p2", 200);
    check("p2_cycles", cyc, 32'd26);
    check("p2_writes", wr_cnt, 32'd4);
    check("p2_cell",   {24'b0, tape[0]}, 32'h00);
    check("p2_out",    {24'b0, last_out}, 32'h00);
    check("p2_out_cnt", out_cnt, 32'd1);

    // [[+]+] on a zero cell, then COUT HALT
    start(128'h87505044, 8, 1'b1);
    run_to_end("p3", 200);
    check("p3_cycles", cyc, 32'd18);
    check("p3_writes", wr_cnt, 32'd0);
    check("p3_out",    {24'b0, last_out}, 32'h00);
    check("p3_halted", {31'b0, halted}, 32'd1);

    // DEC,DECSP,INC,HALT: cell and pointer wrap
    start(128'h8031, 4, 1'b1);
    run_to_end("p4", 200);
    check("p4_cycles", cyc, 32'd11);
    check("p4_cell0",  {24'b0, tape[0]}, 32'hFF);
    check("p4_cellff", {24'b0, tape[255]}, 32'h01);
    check("p4_sp",     {16'b0, tape_addr}, 32'hFFFF);

    // CIN with input stall, COUT with output stall
    out_ready = 1'b0;
    start(128'h876, 3, 1'b1);
    wait_cond("p5_in", 0, 20);
    check("p5_in_cyc", cyc, 32'd2);
    repeat (5) @(posedge clock);
    #1;
    check("p5_stall_ready", {31'b0, in_ready}, 32'd1);
    check("p5_stall_we",    wr_cnt, 32'd0);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 8'h41;
    #1;
    check("p5_hs_we",    {31'b0, tape_we}, 32'd1);
    check("p5_hs_wdata", {24'b0, tape_data_write}, 32'h41);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check("p5_ready_drop", {31'b0, in_ready}, 32'd0);
    wait_cond("p5_out", 1, 20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("p5_out_stall_valid", {31'b0, out_valid}, 32'd1);
      check("p5_out_stall_data",  {24'b0, out_data}, 32'h41);
    end
    out_ready = 1'b1;
    cyc = 0;
    run_to_end("p5", 50);
    check("p5_tape",    {24'b0, tape[0]}, 32'h41);
    check("p5_out",     {24'b0, last_out}, 32'h41);
    check("p5_out_cnt", out_cnt, 32'd1);

    // Seventeen nested '[' on a nonzero cell overflow the stack
    start(128'h444444444444444440, 18, 1'b1);
    run_to_end("p6", 200);
    check("p6_error",  {31'b0, error}, 32'd1);
    check("p6_cycles", cyc, 32'd54);
    check("p6_halted", {31'b0, halted}, 32'd0);
    repeat (10) @(posedge clock);
    #1;
    check("p6_sticky", {31'b0, error}, 32'd1);
    check("p6_writes", wr_cnt, 32'd1);

    // Lone ']'
    start(128'h5, 1, 1'b1);
    run_to_end("p7", 50);
    check("p7_error",  {31'b0, error}, 32'd1);
    check("p7_cycles", cyc, 32'd3);

    // Illegal opcode 12
    start(128'hC, 1, 1'b1);
    run_to_end("p8", 50);
    check("p8_error",  {31'b0, error}, 32'd1);
    check("p8_cycles", cyc, 32'd2);
    check("p8_writes", wr_cnt, 32'd0);

    // Reset during OUT_WAIT restarts from address 0
    out_ready = 1'b0;
    start(128'h870, 3, 1'b1);
    wait_cond("p9_out", 1, 20);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("p9_rst_valid", {31'b0, out_valid}, 32'd0);
    check("p9_rst_pc",    {16'b0, pmem_addr}, 32'h0);
    @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    cyc       = 0;
    run_to_end("p9", 100);
    check("p9_cycles",  cyc, 32'd8);
    check("p9_cell",    {24'b0, tape[0]}, 32'h02);
    check("p9_out",     {24'b0, last_out}, 32'h02);
    check("p9_out_cnt", out_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
